// File: rtl/bit_rev_ram.sv
// Bit-reversal address lookup for the 1024-point radix-2 FFT sample buffer.
// Returns the registered bit-reversed addresses of both samples of a butterfly pair.
module bit_rev_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = ADDR_W + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] DoutA,
  output logic [DATA_W-1:0] DoutB
);

  logic [ADDR_W-1:0] rev;

  // Reversing {addr, lsb} puts the pair's lsb in the MSB, so both outputs share rev(addr).
  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      rev[ADDR_W-1-i] = addr[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DoutA <= '0;
      DoutB <= '0;
    end else begin
      DoutA <= {1'b0, rev};
      DoutB <= {1'b1, rev};
    end
  end

endmodule

// File: tb/tb_bit_rev_ram.sv
// Directed and exhaustive checks of the bit-reversal address lookup.
module tb_bit_rev_ram;

  logic       Clk;
  logic       Reset;
  logic [8:0] addr;
  logic [9:0] DoutA;
  logic [9:0] DoutB;

  int tests = 0;
  int fails = 0;

  bit seen [1024];

  bit_rev_ram #(.ADDR_W(9), .DATA_W(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .addr  (addr),
    .DoutA (DoutA),
    .DoutB (DoutB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [8:0] ref_rev9(input logic [8:0] v);
    logic [8:0] r;
    logic [8:0] t;
    r = '0;
    t = v;
    repeat (9) begin
      r = {r[7:0], t[0]};
      t = t >> 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present a on the falling edge, then sample 1 ns after the next rising edge.
  task automatic step(input string tag, input logic [8:0] a, input logic [9:0] ea, input logic [9:0] eb);
    @(negedge Clk) addr = a;
    @(posedge Clk) #1;
    check({tag, "_A"}, DoutA, ea);
    check({tag, "_B"}, DoutB, eb);
  endtask

  initial begin
    int distinct;
    logic [9:0] ea;
    Reset = 1'b1;
    addr  = 9'd0;
    #12;
    check("por_A", DoutA, 10'd0);
    check("por_B", DoutB, 10'd0);
    @(negedge Clk) Reset = 1'b0;

    // Get non-zero outputs, then assert reset mid-cycle.
    step("pre_rst", 9'd5, 10'd320, 10'd832);
    #2 Reset = 1'b1;
    #1;
    check("rst_async_A", DoutA, 10'd0);
    check("rst_async_B", DoutB, 10'd0);
    @(posedge Clk) #1;
    check("rst_hold_A", DoutA, 10'd0);
    check("rst_hold_B", DoutB, 10'd0);
    @(negedge Clk) Reset = 1'b0;
    @(posedge Clk) #1;
    check("rst_rel_A", DoutA, 10'd320);
    check("rst_rel_B", DoutB, 10'd832);

    step("seq5",   9'd5,   10'd320, 10'd832);
    step("seq10",  9'd10,  10'd160, 10'd672);
    step("seq15",  9'd15,  10'd480, 10'd992);
    step("seq20",  9'd20,  10'd80,  10'd592);
    step("seq500", 9'd500, 10'd95,  10'd607);

    step("bnd0",   9'd0,   10'd0,   10'd512);
    step("bnd511", 9'd511, 10'd511, 10'd1023);
    step("bnd256", 9'd256, 10'd1,   10'd513);
    step("bnd1",   9'd1,   10'd256, 10'd768);

    // Outputs must hold across a mid-cycle addr change until the next rising edge.
    #2 addr = 9'd5;
    #1;
    check("lat_hold_A", DoutA, 10'd256);
    check("lat_hold_B", DoutB, 10'd768);
    @(negedge Clk) #0;
    check("lat_neg_A", DoutA, 10'd256);
    @(posedge Clk) #1;
    check("lat_new_A", DoutA, 10'd320);
    check("lat_new_B", DoutB, 10'd832);

    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    for (int i = 0; i < 512; i++) begin
      @(negedge Clk) addr = 9'(i);
      @(posedge Clk) #1;
      ea = {1'b0, ref_rev9(9'(i))};
      check($sformatf("sweep%0d_A", i), DoutA, ea);
      check($sformatf("sweep%0d_diff", i), DoutB - DoutA, 10'd512);
      seen[DoutA] = 1'b1;
      seen[DoutB] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 1024; i++) if (seen[i]) distinct++;
    check("perm_distinct", 10'(distinct - 1), 10'd1023);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_rev_ram.md
Name: bit_rev_ram

Overview:
- Synchronous bit-reversal address ROM for the 1024-point radix-2 FFT sample buffer.
- Given a 9-bit butterfly-pair index, it returns the two 10-bit bit-reversed sample addresses of the pair (even and odd input index).
- Sits between the FFT load/sequencer counter and the sample RAM read ports A and B.

Parameters:
- ADDR_W, 9, width of the pair index input; N = 2^(ADDR_W+1) = 1024 points.
- DATA_W, 10, width of each output address; fixed at ADDR_W+1.

Ports:
- Clk    input   1   system clock; all state updates on the rising edge.
- Reset  input   1   asynchronous, active-high reset.
- addr   input   9   butterfly-pair index, 0..511.
- DoutA  output  10  bit-reversed address of even sample index {addr,1'b0}.
- DoutB  output  10  bit-reversed address of odd sample index {addr,1'b1}.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-high (Reset).
- Function, where rev9 is the 9-bit bit reversal of addr (bit i goes to bit 8-i):
  - DoutA = bitrev10({addr,0}) = {1'b0, rev9(addr)}.
  - DoutB = bitrev10({addr,1}) = {1'b1, rev9(addr)} = DoutA + 512.
- Outputs are registered, like a block-RAM read. addr sampled at rising edge k appears on DoutA/DoutB after edge k, so latency is 1 cycle.
- Every cycle performs a new lookup. No enable and no handshake; the output holds the last value while addr is stable.
- Reset asserted (async):
  - DoutA and DoutB go to 0 immediately, with no clock needed.
  - Both hold 0 while Reset is high.
  - The first lookup is registered on the first rising edge after Reset deasserts.
- Reset during operation discards the pending lookup. No other state exists.
- Boundaries:
  - addr=0 gives A=0, B=512.
  - addr=511 gives A=511, B=1023.
  - DoutB[9] is always 1 and DoutA[9] is always 0 outside reset.
- Purely combinational address mapping feeding the registers. Implement it as an explicit 512-entry case table or as a generated bit-swap; both must give identical results.
- No X propagation: an X on addr only affects outputs; there is no stored state to corrupt.

Test Plan:
- Reset: assert Reset mid-cycle with addr=5 -> DoutA=0, DoutB=0 immediately and while held. Deassert -> after the next edge, DoutA=320, DoutB=832.
- Directed sequence, one addr per 10 ns clock: addr=5, 10, 15, 20, 500. One cycle later, expect in order:
  - (320, 832)
  - (160, 672)
  - (480, 992)
  - (80, 592)
  - (95, 607)
- Boundaries: addr=0 -> (0, 512); addr=511 -> (511, 1023); addr=256 -> (1, 513); addr=1 -> (256, 768).
- Latency check: change addr between edges -> outputs do not change until the next rising edge, then reflect the new addr.
- Exhaustive sweep of addr 0..511 against a reference bit-reverse model:
  - DoutB - DoutA = 512 for every entry.
  - All 1024 outputs are distinct, so the mapping is a permutation of 0..1023.
